// File: rtl/mips_run_monitor.sv
// Run controller/monitor for the mips_16 core: reset hold, run accounting, halt/timeout detection.
// Optional PC/ALU trace buffer is compiled in when MIPS_MON_TRACE_EN is defined.
module mips_run_monitor #(
  parameter int DATA_W       = 16,
  parameter int RESET_CYCLES = 5,
  parameter int HALT_CYCLES  = 4,
  parameter int MAX_CYCLES   = 1024,
  parameter int TRACE_DEPTH  = 16,
  localparam int CW  = $clog2(MAX_CYCLES + 1),
  localparam int AW  = $clog2(TRACE_DEPTH),
  localparam int TCW = $clog2(TRACE_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   alu_in,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                halted,
  output logic                timeout,
  output logic [CW-1:0]       cycle_count,
  input  logic [AW-1:0]       trace_rd_addr,
  output logic [2*DATA_W-1:0] trace_rd_data,
  output logic [TCW-1:0]      trace_count,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(HALT_CYCLES);
  localparam logic [CW-1:0] CYC_LIM   = CW'(MAX_CYCLES);

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic [DATA_W-1:0]   prev_pc_q, prev_pc_d;
  logic                prev_valid_q, prev_valid_d;
  logic                halted_q, halted_d;
  logic                timeout_q, timeout_d;
  logic                pc_match;
  logic                trace_wr;
  logic                trace_clear;

  // A PC match needs a valid previous sample, so the first RUN cycle never matches.
  assign pc_match = prev_valid_q && (pc_in == prev_pc_q);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    count_d      = count_q;
    stall_d      = stall_q;
    prev_pc_d    = prev_pc_q;
    prev_valid_d = prev_valid_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    trace_wr     = 1'b0;
    trace_clear  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_HOLD;
          hold_d       = '0;
          count_d      = '0;
          stall_d      = '0;
          prev_valid_d = 1'b0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          trace_clear  = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_RUN: begin
        count_d      = count_q + 1'b1;
        prev_pc_d    = pc_in;
        prev_valid_d = 1'b1;
        stall_d      = pc_match ? stall_q + 1'b1 : '0;
        trace_wr     = !pc_match;
        if (stall_d == STALL_LIM) halted_d  = 1'b1;
        if (count_d == CYC_LIM)   timeout_d = 1'b1;
        if ((stall_d == STALL_LIM) || (count_d == CYC_LIM)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      count_q      <= '0;
      stall_q      <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      stall_q      <= stall_d;
      prev_pc_q    <= prev_pc_d;
      prev_valid_q <= prev_valid_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cpu_reset   = (state_q != S_RUN);
  assign busy        = (state_q == S_HOLD) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign cycle_count = count_q;
  assign state_dbg   = state_q;

`ifdef MIPS_MON_TRACE_EN
  logic [2*DATA_W-1:0] mem [TRACE_DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [TCW-1:0]      tcount_q;
  logic [2*DATA_W-1:0] rd_q;
  logic [AW-1:0]       oldest;

  // Until the buffer fills, the oldest entry is slot 0; afterwards it is the next slot to overwrite.
  assign oldest = (tcount_q == TCW'(TRACE_DEPTH)) ? wr_ptr_q : '0;

  always_ff @(posedge clk) begin
    if (reset && trace_wr) mem[wr_ptr_q] <= {pc_in, alu_in};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      tcount_q <= '0;
      rd_q     <= '0;
    end else begin
      rd_q <= mem[oldest + trace_rd_addr];
      if (trace_clear) begin
        wr_ptr_q <= '0;
        tcount_q <= '0;
      end else if (trace_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (tcount_q != TCW'(TRACE_DEPTH)) tcount_q <= tcount_q + 1'b1;
      end
    end
  end

  assign trace_rd_data = rd_q;
  assign trace_count   = tcount_q;
`else
  logic unused_trace;
  assign unused_trace  = ^{trace_rd_addr, alu_in, trace_wr, trace_clear};
  assign trace_rd_data = '0;
  assign trace_count   = '0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: directed runs, run results checked by a done-triggered scoreboard.
module tb_mips_run_monitor;
  localparam int DATA_W = 16;
  localparam int MAXC   = 32;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int AW     = $clog2(DEPTH);
  localparam int TCW    = $clog2(DEPTH + 1);
  localparam int RW     = CW + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] pc_in = '0;
  logic [DATA_W-1:0] alu_in = '0;
  logic              cpu_reset, busy, done, halted, timeout;
  logic [CW-1:0]     cycle_count;
  logic [AW-1:0]     trace_rd_addr = '0;
  logic [2*DATA_W-1:0] trace_rd_data;
  logic [TCW-1:0]    trace_count;
  logic [1:0]        state_dbg;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int run_k = 0;
  logic done_d = 1'b0;
  logic [RW-1:0] exp_q[$];

  mips_run_monitor #(
    .DATA_W(DATA_W), .RESET_CYCLES(5), .HALT_CYCLES(4), .MAX_CYCLES(MAXC), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .halted(halted), .timeout(timeout),
    .cycle_count(cycle_count), .trace_rd_addr(trace_rd_addr), .trace_rd_data(trace_rd_data),
    .trace_count(trace_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: PC pattern per RUN cycle, chosen by mode; ALU value derived from PC.
  always @(negedge clk) begin
    logic [DATA_W-1:0] p;
    if (cpu_reset) run_k = 0;
    else begin
      case (mode)
        0:       p = DATA_W'((run_k < 16) ? run_k : 16);
        2:       p = DATA_W'((run_k < 20) ? run_k : 19);
        default: p = DATA_W'(run_k);
      endcase
      pc_in  = p;
      alu_in = p ^ 16'hA5A5;
      run_k++;
    end
  end

  // Scoreboard monitor: each rising done pops one expected {halted,timeout,cycle_count}.
  always @(negedge clk) begin
    if (reset && done && !done_d) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL run_result: got done with empty queue, required no done");
      end else begin
        chk("run_result", {halted, timeout, cycle_count}, exp_q.pop_front());
        chk("done_cpu_reset", cpu_reset, 1'b1);
        chk("done_busy", busy, 1'b0);
      end
    end
    done_d = done;
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after do_start: expects 5 HOLD cycles, then RUN; pulses start mid-HOLD.
  task automatic check_hold(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_hold_cpu_reset"}, cpu_reset, 1'b1);
      chk({tag, "_hold_busy"}, busy, 1'b1);
      start = (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_run_cpu_reset"}, cpu_reset, 1'b0);
    chk({tag, "_run_busy"}, busy, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_wait_done: got done=0 after 200 cycles, required done=1", tag);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_flags", {busy, done, halted, timeout}, 4'b0);
    chk("rst_count", cycle_count, '0);
    chk("rst_trace", {trace_count, trace_rd_data}, '0);
    chk("rst_state", state_dbg, 2'd0);
    reset = 1'b1;
    @(negedge clk);

    // Halt: PC 0..15 then stuck at 16 -> 4 matches after first 16 -> 21 RUN cycles
    mode = 0;
    exp_q.push_back({1'b1, 1'b0, CW'(21)});
    do_start();
    check_hold("halt");
    wait_done("halt");
    repeat (3) @(negedge clk);
    chk("halt_hold_done", {done, halted, timeout, cpu_reset}, 4'b1101);
    chk("halt_hold_count", cycle_count, CW'(21));

    // Restart from DONE, PC never stalls -> timeout at 32
    mode = 1;
    exp_q.push_back({1'b0, 1'b1, CW'(32)});
    do_start();
    chk("restart_cleared", {halted, timeout, done, busy}, 4'b0001);
    chk("restart_count", cycle_count, '0);
    check_hold("tmo");
    wait_done("tmo");
    chk("tmo_state", state_dbg, 2'd3);

    // Mid-run reset, with start ignored in RUN
    mode = 1;
    do_start();
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_start_ignored", {busy, cpu_reset, state_dbg}, {1'b1, 1'b0, 2'd2});
    chk("run_count_mid", cycle_count, CW'(4));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_cpu_reset", cpu_reset, 1'b1);
    chk("midrst_flags", {busy, done, halted, timeout}, 4'b0);
    chk("midrst_count", {cycle_count, trace_count}, '0);
    chk("midrst_state", state_dbg, 2'd0);
    @(negedge clk);

    // Trace: 20 distinct PCs then stuck at 19 -> halt after 24 RUN cycles
    mode = 2;
    exp_q.push_back({1'b1, 1'b0, CW'(24)});
    do_start();
    wait_done("trace");
    trace_rd_addr = AW'(0);
    @(negedge clk);
`ifdef MIPS_MON_TRACE_EN
    chk("trace_count", trace_count, TCW'(16));
    chk("trace_addr0", trace_rd_data, {16'd4, 16'd4 ^ 16'hA5A5});
    trace_rd_addr = AW'(15);
    @(negedge clk);
    chk("trace_addr15", trace_rd_data, {16'd19, 16'd19 ^ 16'hA5A5});
`else
    chk("trace_count", trace_count, '0);
    chk("trace_addr0", trace_rd_data, '0);
`endif

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
